// File: rtl/rle_stream_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rle_pkg
// Purpose  : Shared FSM states, EOB constants and width helpers for the RLE encoder.
// Revision : 1.0
// ============================================================================
package rle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_ZRL  = 3'd2,
    ST_EMIT = 3'd3,
    ST_EOB  = 3'd4
  } state_t;

  localparam int c_eob_run   = 0;
  localparam int c_eob_value = 0;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int zrl_run(input int run_w);
    return (1 << run_w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rle_stream_enc_if.sv
`default_nettype none
// ============================================================================
// Module   : rle_stream_enc_if
// Purpose  : Coefficient-beat input and (run, value) symbol output handshakes.
// Revision : 1.0
// ============================================================================
interface rle_stream_enc_if #(
  parameter int COEF_W = 8,
  parameter int LANES  = 8,
  parameter int RUN_W  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*COEF_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [RUN_W-1:0]        out_run;
  logic [COEF_W-1:0]       out_value;
  logic                    out_eob;
  logic                    out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_run, out_value, out_eob, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_run, out_value, out_eob, out_last
  );
endinterface
`default_nettype wire

// File: rtl/rle_stream_enc_lane_mux.sv
`default_nettype none
// ============================================================================
// Module   : rle_lane_mux
// Purpose  : Selects one coefficient from a beat (lane 0 = MSB slice) and flags zero.
// Revision : 1.0
// ============================================================================
module rle_lane_mux #(
  parameter int COEF_W = 8,
  parameter int LANES  = 8,
  parameter int LANE_W = 3
) (
  input  logic [LANES*COEF_W-1:0] i_beat,
  input  logic [LANE_W-1:0]       i_lane,
  output logic [COEF_W-1:0]       o_coef,
  output logic                    o_is_zero
);

  always_comb begin
    o_coef = '0;
    for (int l = 0; l < LANES; l++) begin
      if (i_lane == LANE_W'(l)) begin
        o_coef = i_beat[(LANES-1-l)*COEF_W +: COEF_W];
      end
    end
  end

  assign o_is_zero = (o_coef == '0);

endmodule
`default_nettype wire

// File: rtl/rle_stream_enc.sv
`default_nettype none
// ============================================================================
// Module   : rle_stream_enc
// Purpose  : Handshaked run-length encoder turning coefficient beats into (run, value) symbols.
// Revision : 1.0
// ============================================================================
module rle_stream_enc
  import rle_pkg::*;
#(
  parameter int COEF_W    = 8,
  parameter int LANES     = 8,
  parameter int BLOCK_LEN = 64,
  parameter int RUN_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  rle_stream_enc_if.slave  bus
);

  localparam int c_beats  = BLOCK_LEN / LANES;
  localparam int c_beat_w = idx_w(c_beats);
  localparam int c_lane_w = idx_w(LANES);
  localparam int c_zrl_w  = idx_w(BLOCK_LEN / (1 << RUN_W) + 1);
  localparam logic [RUN_W:0]   c_run_lim = (RUN_W+1)'(1 << RUN_W);
  localparam logic [RUN_W-1:0] c_zrl_sym = RUN_W'(zrl_run(RUN_W));

  state_t                  r_state, w_state_nxt;
  logic [LANES*COEF_W-1:0] r_beat;
  logic [c_lane_w-1:0]     r_lane, w_lane_nxt;
  logic [c_beat_w-1:0]     r_beat_idx, w_beat_idx_nxt;
  logic [RUN_W:0]          r_run, w_run_nxt;
  logic [c_zrl_w-1:0]      r_zrl_cnt, w_zrl_nxt;
  logic                    r_out_valid, w_out_valid_nxt;
  logic [RUN_W-1:0]        r_out_run, w_out_run_nxt;
  logic [COEF_W-1:0]       r_out_value, w_out_value_nxt;
  logic                    r_out_eob, w_out_eob_nxt;
  logic                    r_out_last, w_out_last_nxt;

  logic [COEF_W-1:0] w_coef;
  logic              w_is_zero;
  logic              w_in_xfer, w_out_xfer;
  logic              w_first_coef, w_last_lane, w_last_beat, w_last_coef;

  rle_lane_mux #(
    .COEF_W (COEF_W),
    .LANES  (LANES),
    .LANE_W (c_lane_w)
  ) u_lane_mux (
    .i_beat    (r_beat),
    .i_lane    (r_lane),
    .o_coef    (w_coef),
    .o_is_zero (w_is_zero)
  );

  assign bus.in_ready  = (r_state == ST_IDLE) && !reset;
  assign bus.out_valid = r_out_valid;
  assign bus.out_run   = r_out_run;
  assign bus.out_value = r_out_value;
  assign bus.out_eob   = r_out_eob;
  assign bus.out_last  = r_out_last;

  assign w_in_xfer    = bus.in_valid && bus.in_ready;
  assign w_out_xfer   = r_out_valid && bus.out_ready;
  assign w_first_coef = (r_beat_idx == '0) && (r_lane == '0);
  assign w_last_lane  = (r_lane == c_lane_w'(LANES - 1));
  assign w_last_beat  = (r_beat_idx == c_beat_w'(c_beats - 1));
  assign w_last_coef  = w_last_lane && w_last_beat;

  always_comb begin
    w_state_nxt     = r_state;
    w_lane_nxt      = r_lane;
    w_beat_idx_nxt  = r_beat_idx;
    w_run_nxt       = r_run;
    w_zrl_nxt       = r_zrl_cnt;
    w_out_valid_nxt = r_out_valid;
    w_out_run_nxt   = r_out_run;
    w_out_value_nxt = r_out_value;
    w_out_eob_nxt   = r_out_eob;
    w_out_last_nxt  = r_out_last;
    case (r_state)
      ST_IDLE: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_SCAN;
          w_lane_nxt  = '0;
        end
      end
      ST_SCAN: begin
        if (w_first_coef || !w_is_zero) begin
          w_out_valid_nxt = 1'b1;
          w_out_eob_nxt   = 1'b0;
          if (!w_first_coef && (r_zrl_cnt != '0)) begin
            w_state_nxt     = ST_ZRL;
            w_out_run_nxt   = c_zrl_sym;
            w_out_value_nxt = '0;
            w_out_last_nxt  = 1'b0;
          end else begin
            w_state_nxt     = ST_EMIT;
            w_out_run_nxt   = w_first_coef ? '0 : r_run[RUN_W-1:0];
            w_out_value_nxt = w_coef;
            w_out_last_nxt  = w_last_coef;
          end
        end else begin
          if ((r_run + 1'b1) == c_run_lim) begin
            w_run_nxt = '0;
            w_zrl_nxt = r_zrl_cnt + 1'b1;
          end else begin
            w_run_nxt = r_run + 1'b1;
          end
          if (!w_last_lane) begin
            w_lane_nxt = r_lane + 1'b1;
          end else if (w_last_beat) begin
            // Trailing zeros: pending run and ZRLs collapse into a single EOB.
            w_state_nxt     = ST_EOB;
            w_run_nxt       = '0;
            w_zrl_nxt       = '0;
            w_out_valid_nxt = 1'b1;
            w_out_run_nxt   = RUN_W'(c_eob_run);
            w_out_value_nxt = COEF_W'(c_eob_value);
            w_out_eob_nxt   = 1'b1;
            w_out_last_nxt  = 1'b1;
          end else begin
            w_state_nxt    = ST_IDLE;
            w_beat_idx_nxt = r_beat_idx + 1'b1;
          end
        end
      end
      ST_ZRL: begin
        if (w_out_xfer) begin
          w_zrl_nxt = r_zrl_cnt - 1'b1;
          if (r_zrl_cnt == c_zrl_w'(1)) begin
            w_state_nxt     = ST_EMIT;
            w_out_run_nxt   = r_run[RUN_W-1:0];
            w_out_value_nxt = w_coef;
            w_out_last_nxt  = w_last_coef;
          end
        end
      end
      ST_EMIT: begin
        if (w_out_xfer) begin
          w_out_valid_nxt = 1'b0;
          w_run_nxt       = '0;
          if (!w_last_lane) begin
            w_state_nxt = ST_SCAN;
            w_lane_nxt  = r_lane + 1'b1;
          end else if (w_last_beat) begin
            w_state_nxt    = ST_IDLE;
            w_beat_idx_nxt = '0;
          end else begin
            w_state_nxt    = ST_IDLE;
            w_beat_idx_nxt = r_beat_idx + 1'b1;
          end
        end
      end
      ST_EOB: begin
        if (w_out_xfer) begin
          w_out_valid_nxt = 1'b0;
          w_out_eob_nxt   = 1'b0;
          w_state_nxt     = ST_IDLE;
          w_beat_idx_nxt  = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_lane      <= '0;
      r_beat_idx  <= '0;
      r_run       <= '0;
      r_zrl_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_run   <= '0;
      r_out_value <= '0;
      r_out_eob   <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lane      <= w_lane_nxt;
      r_beat_idx  <= w_beat_idx_nxt;
      r_run       <= w_run_nxt;
      r_zrl_cnt   <= w_zrl_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_run   <= w_out_run_nxt;
      r_out_value <= w_out_value_nxt;
      r_out_eob   <= w_out_eob_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_beat <= bus.in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rle_stream_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rle_stream_enc
// Purpose  : Directed self-checking bench for rle_stream_enc.
// Revision : 1.0
// ============================================================================
module tb_rle_stream_enc;

  typedef struct packed {
    logic [3:0] run;
    logic [7:0] value;
    logic       eob;
    logic       last;
  } sym_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic bp_mode = 1'b0;
  int   bp_cnt  = 0;
  int   errors  = 0;
  int   checks  = 0;

  sym_t        got_q[$];
  sym_t        exp_q[$];
  logic [63:0] blk[8];
  sym_t        cur, prev;
  logic        prev_stall = 1'b0;

  rle_stream_enc_if #(.COEF_W(8), .LANES(8), .RUN_W(4)) bus();

  rle_stream_enc #(
    .COEF_W(8), .LANES(8), .BLOCK_LEN(64), .RUN_W(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Downstream ready: always high, or high one cycle in three.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_mode ? ((bp_cnt % 3) == 0) : 1'b1;
      bp_cnt++;
    end
  end

  always @(negedge clk) begin
    cur = {bus.out_run, bus.out_value, bus.out_eob, bus.out_last};
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_hold", 32'(cur), 32'(prev));
      end
      if (bus.out_valid) chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) got_q.push_back(cur);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev = cur;
    end
  end

  task automatic push(input logic [3:0] r, input logic [7:0] v, input logic e, input logic l);
    exp_q.push_back(sym_t'({r, v, e, l}));
  endtask

  task automatic clr();
    for (int b = 0; b < 8; b++) blk[b] = 64'h0;
    exp_q.delete();
  endtask

  task automatic send_beat(input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic run_block(input string tag);
    int n;
    got_q.delete();
    for (int b = 0; b < 8; b++) send_beat(blk[b]);
    n = 0;
    while (got_q.size() < exp_q.size() && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        chk($sformatf("%s_sym%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 64'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_run",   32'(bus.out_run),   32'd0);
    chk("rst_out_value", 32'(bus.out_value), 32'd0);
    chk("rst_out_eob",   32'(bus.out_eob),   32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // DC only
    clr();
    blk[0] = 64'h4200_0000_0000_0000;
    push(4'd0, 8'h42, 1'b0, 1'b0);
    push(4'd0, 8'h00, 1'b1, 1'b1);
    run_block("dc_only");

    // Mixed row
    clr();
    blk[0] = 64'h4204_0000_0D00_0000;
    push(4'd0, 8'h42, 1'b0, 1'b0);
    push(4'd0, 8'h04, 1'b0, 1'b0);
    push(4'd2, 8'h0D, 1'b0, 1'b0);
    push(4'd0, 8'h00, 1'b1, 1'b1);
    run_block("mixed");

    // Two ZRLs before coefficient 40
    clr();
    blk[0] = 64'h0100_0000_0000_0000;
    blk[5] = 64'h0700_0000_0000_0000;
    push(4'd0,  8'h01, 1'b0, 1'b0);
    push(4'd15, 8'h00, 1'b0, 1'b0);
    push(4'd15, 8'h00, 1'b0, 1'b0);
    push(4'd7,  8'h07, 1'b0, 1'b0);
    push(4'd0,  8'h00, 1'b1, 1'b1);
    run_block("zrl");

    // Nonzero last coefficient: no EOB
    clr();
    blk[0] = 64'h0500_0000_0000_0000;
    blk[7] = 64'h0000_0000_0000_0007;
    push(4'd0,  8'h05, 1'b0, 1'b0);
    push(4'd15, 8'h00, 1'b0, 1'b0);
    push(4'd15, 8'h00, 1'b0, 1'b0);
    push(4'd15, 8'h00, 1'b0, 1'b0);
    push(4'd14, 8'h07, 1'b0, 1'b1);
    run_block("tail");

    // Exactly 16 zeros: one ZRL, then run 0
    clr();
    blk[0] = 64'h0100_0000_0000_0000;
    blk[2] = 64'h0009_0000_0000_0000;
    push(4'd0,  8'h01, 1'b0, 1'b0);
    push(4'd15, 8'h00, 1'b0, 1'b0);
    push(4'd0,  8'h09, 1'b0, 1'b0);
    push(4'd0,  8'h00, 1'b1, 1'b1);
    run_block("zrl16");

    // All-zero block: zero DC still emitted
    clr();
    push(4'd0, 8'h00, 1'b0, 1'b0);
    push(4'd0, 8'h00, 1'b1, 1'b1);
    run_block("all_zero");

    // Backpressure
    bp_mode = 1'b1;
    clr();
    blk[0] = 64'h4204_0000_0D00_0000;
    push(4'd0, 8'h42, 1'b0, 1'b0);
    push(4'd0, 8'h04, 1'b0, 1'b0);
    push(4'd2, 8'h0D, 1'b0, 1'b0);
    push(4'd0, 8'h00, 1'b1, 1'b1);
    run_block("bp_mixed");
    clr();
    blk[0] = 64'h0100_0000_0000_0000;
    blk[2] = 64'h0009_0000_0000_0000;
    push(4'd0,  8'h01, 1'b0, 1'b0);
    push(4'd15, 8'h00, 1'b0, 1'b0);
    push(4'd0,  8'h09, 1'b0, 1'b0);
    push(4'd0,  8'h00, 1'b1, 1'b1);
    run_block("bp_zrl16");
    bp_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Mid-block reset after 3 beats
    send_beat(64'h1100_0000_0000_0003);
    send_beat(64'h0000_0000_0000_0000);
    send_beat(64'h0500_0000_0000_0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clr();
    blk[0] = 64'h4200_0000_0000_0000;
    push(4'd0, 8'h42, 1'b0, 1'b0);
    push(4'd0, 8'h00, 1'b1, 1'b1);
    run_block("after_rst");

    // Negative coefficients pass verbatim
    clr();
    blk[0] = 64'h42F2_0000_0000_0080;
    push(4'd0, 8'h42, 1'b0, 1'b0);
    push(4'd0, 8'hF2, 1'b0, 1'b0);
    push(4'd5, 8'h80, 1'b0, 1'b0);
    push(4'd0, 8'h00, 1'b1, 1'b1);
    run_block("negative");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rle_stream_enc.md
Name: rle_stream_enc

Overview:
- Parametrised, handshaked run-length encoder for zigzag-ordered quantised JPEG coefficients.
- Accepts one beat of LANES coefficients at a time and serialises each block into (run, value) symbols.
- Inserts ZRL symbols for long zero runs and an EOB symbol when a block ends in zeros.
- Sits between the zigzag/quantiser stage and the Huffman encoder; generalises the fixed 64-bit-in/96-bit-out RLE top with width, lane and block-length parameters plus valid/ready flow control.

Parameters:
- COEF_W, 8: bits per coefficient, two's complement.
- LANES, 8: coefficients per input beat.
- BLOCK_LEN, 64: coefficients per block. Must be a multiple of LANES.
- RUN_W, 4: width of the run field. ZRL run value is 2^RUN_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LANES*COEF_W  beat. Lane 0 is the MSB slice and comes first in scan order.
- out_valid  out  1  symbol valid.
- out_ready  in  1  downstream accepts symbol.
- out_run  out  RUN_W  preceding zero count.
- out_value  out  COEF_W  coefficient, verbatim.
- out_eob  out  1  symbol is EOB (run 0, value 0).
- out_last  out  1  final symbol of block.

Behaviour:
- Reset: while reset is high on a clock edge, the following clear to 0: out_valid, out_run, out_value, out_eob, out_last, run, zrl_cnt, lane index, beat index. State goes to IDLE. in_ready is 0 while reset is asserted.
- Reset mid-block aborts the block with no EOB. The next accepted beat is beat 0 of a new block.
- Transfers occur on an edge where valid && ready.
- out_* must be held stable while out_valid && !out_ready.
- in_ready = (state==IDLE) && !reset.
- FSM states: IDLE, SCAN, ZRL, EMIT, EOB.
- IDLE: on input transfer, register the beat, set lane index to 0, go to SCAN.
- SCAN: examines one lane per cycle.
  - Coefficient 0 of the block (DC) is always emitted as (0, value), even when zero.
  - AC nonzero: if zrl_cnt>0, go to ZRL; else go to EMIT with (run, value).
  - AC zero: run++. When run reaches 2^RUN_W, run<=0 and zrl_cnt++. Advance the lane.
- ZRL: emit (2^RUN_W-1, 0), one per output transfer, decrementing zrl_cnt. When zrl_cnt reaches 0, go to EMIT.
- EMIT: hold the symbol until it transfers, then clear run.
- Scan advance (after a zero in SCAN, or after an EMIT transfer):
  - Next lane if lane<LANES-1.
  - Otherwise, on the last beat of the block, end of block.
  - Otherwise IDLE.
- End of block:
  - Last coefficient nonzero: its symbol carries out_last=1 and there is no EOB.
  - Otherwise pending run and zrl_cnt are discarded (ZRLs are never emitted without a following nonzero). Go to EOB: emit (0, 0) with out_eob=1 and out_last=1, then IDLE with the beat index cleared.
- Latency: DC symbol out_valid is asserted 2 cycles after the input transfer (SCAN cycle, then EMIT). Each lane costs ≥1 cycle. Worst case per beat is LANES cycles plus symbol/ZRL cycles.
- Widths:
  - Beat index: clog2(BLOCK_LEN/LANES) bits.
  - Lane index: clog2(LANES) bits.
  - zrl_cnt: clog2(BLOCK_LEN/2^RUN_W + 1) bits.
  - Run counter: RUN_W+1 bits internally.
- Negative values pass unchanged, e.g. 0xF2 → out_value 0xF2.

Decomposition:
- Package rle_pkg: FSM state enum, ZRL_RUN = 2^RUN_W-1, EOB encoding constants, index-width helper functions.
- Sub-module rle_lane_mux: combinational selection of coefficient lane_idx from the registered beat, with MSB-first slicing. Also supplies the is_zero flag.

Test Plan:
- DC only: beat0=0x42_00_00_00_00_00_00_00, beats 1–7 zero → (0,0x42); EOB (0,0,eob=1,last=1). Exactly 2 symbols.
- Mixed row: beat0=0x42_04_00_00_0D_00_00_00, rest zero → (0,42), (0,04), (2,0D), EOB.
- ZRL: DC=0x01, coef40=0x07 (beat5 lane0), rest zero → (0,01), (15,0), (15,0), (7,07), EOB.
- Tail nonzero: DC=0x05, coef63=0x07, rest zero → (0,05), (15,0)×3, (14,07) with last=1. No EOB.
- Backpressure: mixed-row block with out_ready high only 1 cycle in 3 → identical sequence, no drop or duplicate. out_* are stable while stalled. in_ready stays 0 until EOB transfers.
- Mid-block reset: 3 beats accepted, then reset for 1 cycle → out_valid=0 and in_ready=0 during reset. The following DC-only block yields exactly the DC-only output; F2 in a lane is emitted as value 0xF2.
